time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time editor for a clock display.
// A long btn_m press enters edit mode with a snapshot of the live time.
// btn_r increments and btn_l decrements the selected field. A short btn_m
// press steps through hh, mm, ss and then commits. A long btn_m press, or
// leaving the clock mode, abandons the edit.
module time_set_ctrl #(
   parameter int DEBOUNCE   = 2500000,
   parameter int LONGPRESS  = 100000000,
   parameter int BLINK_HALF = 50000000,
   parameter int CLOCK_MODE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_l,
   input  logic       btn_m,
   input  logic       btn_r,
   input  logic [3:0] mode,
   input  logic [4:0] cur_hh,
   input  logic [5:0] cur_mm,
   input  logic [5:0] cur_ss,
   output logic       set,
   output logic       load,
   output logic [4:0] hh_out,
   output logic [5:0] mm_out,
   output logic [5:0] ss_out,
   output logic [1:0] field,
   output logic       blink
);

   // Counter widths and the thresholds expressed at those widths.
   localparam int CW = $clog2(LONGPRESS + 1);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [CW-1:0] DEB_M1 = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] DEB    = CW'(DEBOUNCE);
   localparam logic [CW-1:0] LP_M1  = CW'(LONGPRESS - 1);
   localparam logic [CW-1:0] LP     = CW'(LONGPRESS);
   localparam logic [BW-1:0] BH_M1  = BW'(BLINK_HALF - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EDIT_HH = 3'd1,
      EDIT_MM = 3'd2,
      EDIT_SS = 3'd3,
      COMMIT  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] press_cnt_q, press_cnt_d;
   logic          btn_m_prev_q, btn_m_prev_d;
   logic [4:0]    hh_q, hh_d;
   logic [5:0]    mm_q, mm_d;
   logic [5:0]    ss_q, ss_d;
   logic          blink_q, blink_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;

   logic          one_btn;
   logic          act_inc, act_dec, act_short, act_long;
   logic          mode_ok;
   logic          edited;
   logic          in_edit_d;

   // Wrap helpers for the 0..59 minute and second fields.
   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v >= 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] dec60(input logic [5:0] v);
      return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
   endfunction

   // Press qualification: count while exactly one button is held, then decode actions.
   always_comb begin
      one_btn      = (({1'b0, btn_l} + {1'b0, btn_m} + {1'b0, btn_r}) == 2'd1);
      btn_m_prev_d = btn_m;
      press_cnt_d  = '0;
      if (one_btn) begin
         press_cnt_d = (press_cnt_q == LP) ? press_cnt_q : press_cnt_q + 1'b1;
      end
      // Actions fire on the cycle in which the counter steps onto its threshold.
      act_inc   = one_btn && btn_r && (press_cnt_q == DEB_M1);
      act_dec   = one_btn && btn_l && (press_cnt_q == DEB_M1);
      act_long  = one_btn && btn_m && (press_cnt_q == LP_M1);
      // press_cnt_q still holds the btn_m-only hold time on the release cycle.
      act_short = btn_m_prev_q && !btn_m && (press_cnt_q >= DEB) && (press_cnt_q < LP);
      mode_ok   = (mode == 4'(CLOCK_MODE));
   end

   // Edit state machine: next state and edit register updates.
   always_comb begin
      state_d = state_q;
      hh_d    = hh_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      edited  = 1'b0;
      case (state_q)
         IDLE: begin
            if (act_long && mode_ok) begin
               hh_d    = cur_hh;
               mm_d    = cur_mm;
               ss_d    = cur_ss;
               state_d = EDIT_HH;
            end
         end
         EDIT_HH, EDIT_MM, EDIT_SS: begin
            if (!mode_ok || act_long) begin
               // Abandon the edit; edit registers keep their values.
               state_d = IDLE;
            end else if (act_short) begin
               case (state_q)
                  EDIT_HH: state_d = EDIT_MM;
                  EDIT_MM: state_d = EDIT_SS;
                  default: state_d = COMMIT;
               endcase
            end else if (act_inc || act_dec) begin
               edited = 1'b1;
               case (state_q)
                  EDIT_HH: begin
                     if (act_inc) hh_d = (hh_q >= 5'd23) ? 5'd0 : hh_q + 5'd1;
                     else         hh_d = (hh_q == 5'd0 || hh_q > 5'd23) ? 5'd23 : hh_q - 5'd1;
                  end
                  EDIT_MM: mm_d = act_inc ? inc60(mm_q) : dec60(mm_q);
                  default: ss_d = act_inc ? inc60(ss_q) : dec60(ss_q);
               endcase
            end
         end
         COMMIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Blink generator: restart high on entering an edit state or after any edit.
   always_comb begin
      in_edit_d   = (state_d == EDIT_HH) || (state_d == EDIT_MM) || (state_d == EDIT_SS);
      blink_d     = 1'b0;
      blink_cnt_d = '0;
      if (in_edit_d) begin
         if (state_d != state_q || edited) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
         end else if (blink_cnt_q == BH_M1) begin
            blink_d     = !blink_q;
            blink_cnt_d = '0;
         end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         press_cnt_q  <= '0;
         btn_m_prev_q <= 1'b0;
         hh_q         <= '0;
         mm_q         <= '0;
         ss_q         <= '0;
         blink_q      <= 1'b0;
         blink_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         press_cnt_q  <= press_cnt_d;
         btn_m_prev_q <= btn_m_prev_d;
         hh_q         <= hh_d;
         mm_q         <= mm_d;
         ss_q         <= ss_d;
         blink_q      <= blink_d;
         blink_cnt_q  <= blink_cnt_d;
      end
   end

   // Output decode straight from registered state.
   always_comb begin
      set    = (state_q != IDLE);
      load   = (state_q == COMMIT);
      hh_out = hh_q;
      mm_out = mm_q;
      ss_out = ss_q;
      blink  = blink_q;
      case (state_q)
         EDIT_HH: field = 2'd1;
         EDIT_MM: field = 2'd2;
         EDIT_SS: field = 2'd3;
         default: field = 2'd0;
      endcase
   end

endmodule
